// File: rtl/bus_controller.sv
// bus_controller
// Multi-cycle bus sequencer that sits directly behind the CPU bus interface
// stage. It decodes the word address into ROM, RAM or IO space, drives the
// selected device for a fixed number of wait states (ROM/RAM) or until the
// IO device acknowledges, and returns registered read data together with a
// one-cycle ready or bus-error pulse.
//
// Ports
//   clock, reset_n                 clock and asynchronous active-low reset
//   address, data_strobes          word address [31:2] and byte-lane enables
//   align_error                    alignment fault from the bus interface
//   read, write                    level request inputs
//   cpu_data_out                   lane-positioned write data
//   cpu_data_in                    registered read data back to the CPU
//   ready, bus_error               one-cycle completion / failure pulses
//   mem_address, mem_data_out,
//   mem_strobes                    latched transaction fields to the devices
//   mem_read, mem_write            device direction strobes
//   rom_cs, ram_cs, io_cs          one-hot device selects
//   rom_data, ram_data, io_data    device read data
//   io_ack                         IO device completion
module bus_controller #(
  parameter int unsigned ROM_WAIT   = 1,
  parameter int unsigned RAM_WAIT   = 0,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [29:0] address,
  input  logic [3:0]  data_strobes,
  input  logic        align_error,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] cpu_data_out,
  output logic [31:0] cpu_data_in,
  output logic        ready,
  output logic        bus_error,
  output logic [29:0] mem_address,
  output logic [31:0] mem_data_out,
  output logic [3:0]  mem_strobes,
  output logic        mem_read,
  output logic        mem_write,
  output logic        rom_cs,
  output logic        ram_cs,
  output logic        io_cs,
  input  logic [31:0] rom_data,
  input  logic [31:0] ram_data,
  input  logic [31:0] io_data,
  input  logic        io_ack
);

  typedef enum logic [2:0] {IDLE, ACCESS, ACK, DONE, ERROR} state_t;
  typedef enum logic [1:0] {REG_NONE, REG_ROM, REG_RAM, REG_IO} region_t;

  localparam logic [7:0] ROM_LOAD = 8'(ROM_WAIT);
  localparam logic [7:0] RAM_LOAD = 8'(RAM_WAIT);
  localparam logic [7:0] IO_LOAD  = 8'(IO_TIMEOUT);

  state_t      stateQ;
  region_t     regionQ;
  region_t     decodeRegion;
  logic [7:0]  counterQ;
  logic [7:0]  counterLoad;
  logic        writeQ;
  logic [31:0] cpuDataQ;
  logic        readyQ;
  logic        busErrorQ;
  logic [29:0] memAddressQ;
  logic [31:0] memDataQ;
  logic [3:0]  memStrobesQ;
  logic        memReadQ;
  logic        memWriteQ;
  logic        romCsQ;
  logic        ramCsQ;
  logic        ioCsQ;
  logic        requestBad;

  // Region decode on byte-address bits 31:28, which are word-address bits
  // 29:26. The counter load value follows the region so IDLE can latch it
  // in one step.
  always_comb begin
    decodeRegion = REG_NONE;
    counterLoad  = 8'd0;
    case (address[29:26])
      4'h0: begin
        decodeRegion = REG_ROM;
        counterLoad  = ROM_LOAD;
      end
      4'h1: begin
        decodeRegion = REG_RAM;
        counterLoad  = RAM_LOAD;
      end
      4'hF: begin
        decodeRegion = REG_IO;
        counterLoad  = IO_LOAD;
      end
      default: begin
        decodeRegion = REG_NONE;
        counterLoad  = 8'd0;
      end
    endcase
  end

  // A request is rejected outright for a read/write conflict, an alignment
  // fault, or an access to unmapped space.
  always_comb begin
    requestBad = (read && write) || align_error ||
                 ((read || write) && (decodeRegion == REG_NONE));
  end

  // Sequencer. All outputs are registered here; ready and bus_error default
  // low every cycle so they can only ever be single-cycle pulses. An IO
  // acknowledge passes through the ACK state so the read data is captured
  // while io_data is valid and completion is reported one cycle later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateQ      <= IDLE;
      regionQ     <= REG_NONE;
      counterQ    <= 8'd0;
      writeQ      <= 1'b0;
      cpuDataQ    <= 32'h0;
      readyQ      <= 1'b0;
      busErrorQ   <= 1'b0;
      memAddressQ <= 30'h0;
      memDataQ    <= 32'h0;
      memStrobesQ <= 4'h0;
      memReadQ    <= 1'b0;
      memWriteQ   <= 1'b0;
      romCsQ      <= 1'b0;
      ramCsQ      <= 1'b0;
      ioCsQ       <= 1'b0;
    end else begin
      readyQ    <= 1'b0;
      busErrorQ <= 1'b0;
      case (stateQ)
        IDLE: begin
          if (requestBad) begin
            busErrorQ <= 1'b1;
            stateQ    <= ERROR;
          end else if (read || write) begin
            regionQ     <= decodeRegion;
            counterQ    <= counterLoad;
            writeQ      <= write;
            memAddressQ <= address;
            memDataQ    <= cpu_data_out;
            memStrobesQ <= data_strobes;
            memReadQ    <= read;
            memWriteQ   <= write;
            romCsQ      <= (decodeRegion == REG_ROM);
            ramCsQ      <= (decodeRegion == REG_RAM);
            ioCsQ       <= (decodeRegion == REG_IO);
            stateQ      <= ACCESS;
          end
        end
        ACCESS: begin
          if (regionQ == REG_IO) begin
            // Acknowledge takes priority over an expiring timeout.
            if (io_ack) begin
              if (!writeQ) begin
                cpuDataQ <= io_data;
              end
              ioCsQ     <= 1'b0;
              memReadQ  <= 1'b0;
              memWriteQ <= 1'b0;
              stateQ    <= ACK;
            end else if (counterQ == 8'd0) begin
              ioCsQ     <= 1'b0;
              memReadQ  <= 1'b0;
              memWriteQ <= 1'b0;
              busErrorQ <= 1'b1;
              stateQ    <= ERROR;
            end else begin
              counterQ <= counterQ - 8'd1;
            end
          end else if (counterQ == 8'd0) begin
            if (!writeQ) begin
              cpuDataQ <= (regionQ == REG_ROM) ? rom_data : ram_data;
            end
            romCsQ    <= 1'b0;
            ramCsQ    <= 1'b0;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
            readyQ    <= 1'b1;
            stateQ    <= DONE;
          end else begin
            counterQ <= counterQ - 8'd1;
          end
        end
        ACK: begin
          readyQ <= 1'b1;
          stateQ <= DONE;
        end
        DONE: begin
          stateQ <= IDLE;
        end
        ERROR: begin
          stateQ <= IDLE;
        end
        default: begin
          stateQ <= IDLE;
        end
      endcase
    end
  end

  assign cpu_data_in  = cpuDataQ;
  assign ready        = readyQ;
  assign bus_error    = busErrorQ;
  assign mem_address  = memAddressQ;
  assign mem_data_out = memDataQ;
  assign mem_strobes  = memStrobesQ;
  assign mem_read     = memReadQ;
  assign mem_write    = memWriteQ;
  assign rom_cs       = romCsQ;
  assign ram_cs       = ramCsQ;
  assign io_cs        = ioCsQ;

endmodule

// File: tb/tb_bus_controller.sv
// tb_bus_controller
// Self-checking bench for bus_controller with ROM_WAIT=3, RAM_WAIT=0 and
// IO_TIMEOUT=4. Each transaction pushes its expected outcome (error or
// ready, read data, latency in cycles) onto a scoreboard queue; the entry
// is popped and compared when the DUT raises ready or bus_error.
module tb_bus_controller;

  typedef struct {
    bit          isErr;
    logic [31:0] data;
    int          latency;
  } expect_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [29:0] address = '0;
  logic [3:0]  data_strobes = '0;
  logic        align_error = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] cpu_data_out = '0;
  logic [31:0] cpu_data_in;
  logic        ready;
  logic        bus_error;
  logic [29:0] mem_address;
  logic [31:0] mem_data_out;
  logic [3:0]  mem_strobes;
  logic        mem_read;
  logic        mem_write;
  logic        rom_cs;
  logic        ram_cs;
  logic        io_cs;
  logic [31:0] rom_data = '0;
  logic [31:0] ram_data = '0;
  logic [31:0] io_data = '0;
  logic        io_ack = 1'b0;

  expect_t     scoreboard[$];
  logic [31:0] lastRead = 32'h0;
  int          checkCount = 0;
  int          passCount = 0;

  bus_controller #(
    .ROM_WAIT(3),
    .RAM_WAIT(0),
    .IO_TIMEOUT(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .address(address),
    .data_strobes(data_strobes),
    .align_error(align_error),
    .read(read),
    .write(write),
    .cpu_data_out(cpu_data_out),
    .cpu_data_in(cpu_data_in),
    .ready(ready),
    .bus_error(bus_error),
    .mem_address(mem_address),
    .mem_data_out(mem_data_out),
    .mem_strobes(mem_strobes),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .rom_cs(rom_cs),
    .ram_cs(ram_cs),
    .io_cs(io_cs),
    .rom_data(rom_data),
    .ram_data(ram_data),
    .io_data(io_data),
    .io_ack(io_ack)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  // Drives one request at a falling edge (that cycle is cycle 0), records
  // the expected outcome, then watches cycles 1.. for the completion pulse.
  // csSel: 0 none, 1 ROM, 2 RAM, 3 IO. ioAckCycle 0 means never acknowledge.
  // The address input is scrambled after cycle 1 to show it is ignored.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [31:0] byteAddr, input logic [3:0] strb,
                               input logic [31:0] wdata, input logic align,
                               input bit expErr, input int expLat,
                               input int ioAckCycle, input int csSel,
                               input int expCsCycles, input bit holdReq);
    expect_t     e;
    expect_t     got;
    logic [29:0] wordAddr;
    logic        selCs;
    int          csCount;
    int          otherCs;
    bit          seen;
    bit          fieldsOk;
    wordAddr = byteAddr[31:2];
    e.isErr   = expErr;
    e.latency = expLat;
    e.data    = lastRead;
    if (rd && !wr && !expErr) begin
      case (csSel)
        1: e.data = rom_data;
        2: e.data = ram_data;
        default: e.data = io_data;
      endcase
      lastRead = e.data;
    end
    scoreboard.push_back(e);
    read = rd;
    write = wr;
    address = wordAddr;
    data_strobes = strb;
    cpu_data_out = wdata;
    align_error = align;
    csCount = 0;
    otherCs = 0;
    seen = 1'b0;
    fieldsOk = 1'b1;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clock);
      case (csSel)
        1: selCs = rom_cs;
        2: selCs = ram_cs;
        3: selCs = io_cs;
        default: selCs = 1'b0;
      endcase
      if (selCs) csCount++;
      otherCs += int'(rom_cs) + int'(ram_cs) + int'(io_cs) - int'(selCs);
      if ((rom_cs || ram_cs || io_cs) &&
          (mem_address !== wordAddr || mem_strobes !== strb ||
           mem_data_out !== wdata || mem_read !== rd || mem_write !== wr)) begin
        fieldsOk = 1'b0;
      end
      if (ready || bus_error) begin
        got = scoreboard.pop_front();
        checkOutput({tag, ":pulse"}, {126'h0, ready, bus_error},
                    got.isErr ? 128'h1 : 128'h2);
        checkOutput({tag, ":latency"}, 128'(k), 128'(got.latency));
        checkOutput({tag, ":rdata"}, 128'(cpu_data_in), 128'(got.data));
        seen = 1'b1;
        if (!holdReq) begin
          read = 1'b0;
          write = 1'b0;
          align_error = 1'b0;
        end
      end
      io_ack = (k == ioAckCycle);
      if (k == 1) address = ~wordAddr;
    end
    io_ack = 1'b0;
    if (!seen) begin
      checkOutput({tag, ":timeout"}, 128'h0, 128'h1);
      got = scoreboard.pop_front();
    end
    checkOutput({tag, ":cs cycles"}, 128'(csCount), 128'(expCsCycles));
    checkOutput({tag, ":other cs"}, 128'(otherCs), 128'h0);
    if (expCsCycles > 0) begin
      checkOutput({tag, ":latched fields"}, 128'(fieldsOk), 128'h1);
    end
    @(negedge clock);
    checkOutput({tag, ":pulse width"},
                {123'h0, ready, bus_error, rom_cs, ram_cs, io_cs}, 128'h0);
  endtask

  // Test sequence.
  initial begin
    int quiet;
    repeat (2) @(negedge clock);
    checkOutput("reset state",
                {23'h0, cpu_data_in, ready, bus_error, mem_address, mem_data_out,
                 mem_strobes, mem_read, mem_write, rom_cs, ram_cs, io_cs}, 128'h0);
    reset_n = 1'b1;
    @(negedge clock);

    ram_data = 32'hDEADBEEF;
    applyStimulus("ram read", 1'b1, 1'b0, 32'h10000004, 4'hF, 32'h0, 1'b0,
                  1'b0, 2, 0, 2, 1, 1'b0);
    applyStimulus("rom write", 1'b0, 1'b1, 32'h00000010, 4'b0011, 32'hFFFF1234,
                  1'b0, 1'b0, 5, 0, 1, 4, 1'b0);
    rom_data = 32'h12345678;
    applyStimulus("rom read", 1'b1, 1'b0, 32'h00000020, 4'hF, 32'h0, 1'b0,
                  1'b0, 5, 0, 1, 4, 1'b0);
    io_data = 32'h000000A5;
    applyStimulus("io read ack", 1'b1, 1'b0, 32'hF0000000, 4'hF, 32'h0, 1'b0,
                  1'b0, 5, 3, 3, 3, 1'b0);
    io_data = 32'h11111111;
    applyStimulus("io timeout", 1'b1, 1'b0, 32'hF0000004, 4'hF, 32'h0, 1'b0,
                  1'b1, 6, 0, 3, 5, 1'b0);
    applyStimulus("io write ack", 1'b0, 1'b1, 32'hF0000008, 4'b1100, 32'hABCD0000,
                  1'b0, 1'b0, 3, 1, 3, 1, 1'b0);
    applyStimulus("unmapped", 1'b1, 1'b0, 32'h20000000, 4'hF, 32'h0, 1'b0,
                  1'b1, 1, 0, 0, 0, 1'b0);
    applyStimulus("align error", 1'b1, 1'b0, 32'h10000000, 4'hF, 32'h0, 1'b1,
                  1'b1, 1, 0, 0, 0, 1'b0);
    applyStimulus("read+write", 1'b1, 1'b1, 32'h10000000, 4'hF, 32'h0, 1'b0,
                  1'b1, 1, 0, 0, 0, 1'b0);

    ram_data = 32'hCAFEF00D;
    applyStimulus("b2b first", 1'b1, 1'b0, 32'h10000008, 4'hF, 32'h0, 1'b0,
                  1'b0, 2, 0, 2, 1, 1'b1);
    ram_data = 32'h0BADF00D;
    applyStimulus("b2b second", 1'b1, 1'b0, 32'h10000008, 4'hF, 32'h0, 1'b0,
                  1'b0, 2, 0, 2, 1, 1'b0);

    // Asynchronous reset in the middle of a RAM access.
    ram_data = 32'h55AA55AA;
    read = 1'b1;
    address = 30'h04000010;
    @(negedge clock);
    checkOutput("mid reset:in access", 128'(ram_cs), 128'h1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid reset:outputs",
                {23'h0, cpu_data_in, ready, bus_error, mem_address, mem_data_out,
                 mem_strobes, mem_read, mem_write, rom_cs, ram_cs, io_cs}, 128'h0);
    read = 1'b0;
    lastRead = 32'h0;
    @(negedge clock);
    reset_n = 1'b1;
    quiet = 0;
    repeat (3) begin
      @(negedge clock);
      quiet += int'(ready) + int'(bus_error) + int'(ram_cs);
    end
    checkOutput("mid reset:quiet", 128'(quiet), 128'h0);
    applyStimulus("after reset", 1'b1, 1'b0, 32'h10000040, 4'hF, 32'h0, 1'b0,
                  1'b0, 2, 0, 2, 1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
